sync_updown_counter: RTL and testbench

Parameterised synchronous binary up/down counter with count enable and direction select. It is a general-purpose sequencing and timing primitive that can be dropped into any single-clock datapath. It wraps modulo 2^WIDTH in both directions. A combinational terminal-count flag supports cascading.

---
 rtl/sync_updown_counter.sv | 62 ++++++
 tb/tb_sync_updown_counter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sync_updown_counter.sv
// sync_updown_counter: parameterised synchronous up/down binary counter.
// Wraps modulo 2^WIDTH in both directions. The terminal-count flag is
// combinational and is raised in the cycle before a wrap, so counters can
// be cascaded by feeding tc into the enable of the next stage.
// Reset is synchronous and active-low; while it is asserted, count is
// cleared on the next edge and tc is held low.

module sync_updown_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] count_r;
  logic             at_max_s;
  logic             at_min_s;
  logic             tc_s;

  // Count register: reset clears it; otherwise it steps up or down when
  // enabled and holds when not. Plain +/- gives modulo 2^WIDTH wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= ZERO;
    end else if (enable) begin
      if (up) begin
        count_r <= count_r + ONE;
      end else begin
        count_r <= count_r - ONE;
      end
    end else begin
      count_r <= count_r;
    end
  end

  // Terminal count: the next enabled step in the current direction wraps.
  // Gated by reset so a pending clear never looks like a wrap.
  always_comb begin
    at_max_s = 1'b0;
    at_min_s = 1'b0;
    tc_s     = 1'b0;
    at_max_s = (count_r == ALL_ONES);
    at_min_s = (count_r == ZERO);
    if (reset) begin
      tc_s = enable & ((up & at_max_s) | (~up & at_min_s));
    end else begin
      tc_s = 1'b0;
    end
  end

  assign count = count_r;
  assign tc    = tc_s;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Directed testbench for sync_updown_counter (WIDTH=4).
// Inputs are changed 1 time unit after a rising edge; outputs are sampled
// there as well, well away from the active edge.

module tb_sync_updown_counter;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       up;
  logic [3:0] count;
  logic       tc;

  int vectors;
  int miscompares;

  sync_updown_counter #(.WIDTH(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .up     (up),
    .count  (count),
    .tc     (tc)
  );

  // 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors = vectors + 1;
    if (got !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", tag, got, got, exp, exp);
    end
  endtask

  // Advance one rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset  = 1'b0;
    enable = 1'b1;
    up     = 1'b1;
    @(negedge clk);

    // Reset with enable=1, up=1.
    step();
    check("rst_count", 32'(count), 32'd0);
    check("rst_tc_up", 32'(tc), 32'd0);
    // count=0, down, enabled: would be tc=1 if not gated by reset.
    up = 1'b0;
    #1;
    check("rst_tc_gated", 32'(tc), 32'd0);

    // Release reset with enable=0: holds at 0.
    reset  = 1'b1;
    enable = 1'b0;
    step();
    check("rel_hold0", 32'(count), 32'd0);
    step();
    check("rel_hold1", 32'(count), 32'd0);

    // Up count 1..5.
    enable = 1'b1;
    up     = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("up_%0d", i), 32'(count), 32'(i));
    end
    // Continue to 15.
    for (int i = 6; i <= 15; i++) step();
    check("up_15", 32'(count), 32'd15);
    check("tc_at_15", 32'(tc), 32'd1);
    step();
    check("wrap_up", 32'(count), 32'd0);
    check("tc_after_wrap_up", 32'(tc), 32'd0);

    // Climb to 5, then count down to 0.
    for (int i = 1; i <= 5; i++) step();
    check("pre_down_5", 32'(count), 32'd5);
    up = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      step();
      check($sformatf("down_%0d", i), 32'(count), 32'(i));
    end
    check("tc_at_0", 32'(tc), 32'd1);
    step();
    check("wrap_down", 32'(count), 32'd15);
    check("tc_at_15_down", 32'(tc), 32'd0);
    step();
    check("down_14", 32'(count), 32'd14);

    // Down from 14 to 7, then direction change.
    for (int i = 0; i < 7; i++) step();
    check("at_7", 32'(count), 32'd7);
    step();
    check("dir_down_6", 32'(count), 32'd6);
    up = 1'b1;
    step();
    check("dir_up_7", 32'(count), 32'd7);
    check("tc_at_7", 32'(tc), 32'd0);

    // Up to 9, then hold with up toggling.
    step();
    step();
    check("at_9", 32'(count), 32'd9);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      up = ~up;
      step();
      check($sformatf("hold_%0d", i), 32'(count), 32'd9);
      check($sformatf("hold_tc_%0d", i), 32'(tc), 32'd0);
    end
    enable = 1'b1;
    up     = 1'b1;
    step();
    check("reenable_10", 32'(count), 32'd10);

    // Mid-operation reset.
    step();
    step();
    check("at_12", 32'(count), 32'd12);
    reset = 1'b0;
    step();
    check("mid_rst", 32'(count), 32'd0);
    reset = 1'b1;
    step();
    check("resume_1", 32'(count), 32'd1);
    // Reset pulse between edges: no effect without an edge.
    reset = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("pulse_no_edge", 32'(count), 32'd1);
    step();
    check("after_pulse_2", 32'(count), 32'd2);

    // X on enable/up during reset must not corrupt the cleared value.
    reset  = 1'b0;
    enable = 1'bx;
    up     = 1'bx;
    step();
    check("x_rst_count", 32'(count), 32'd0);
    check("x_rst_tc", 32'(tc), 32'd0);
    reset  = 1'b1;
    enable = 1'b1;
    up     = 1'b0;
    step();
    check("x_then_down", 32'(count), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
